// File: rtl/mode_executor.sv
// mode_executor: executes the hood mode selected upstream. It drives the fan
// level, the hurricane / self-clean / cooldown countdowns and the completion
// pulses.
//
// Optional feature: define CLEAN_REMINDER_EN to build the run-time usage
// counter and the clean_reminder flag. Without it, clean_reminder is tied to 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | powered on, fan off, waiting for a mode
// RUN1     | fan level 1, follows mode_state
// RUN2     | fan level 2, follows mode_state
// HURR     | fan level 3, counts down HURRICANE_SEC, then forced to RUN2
// COOLDOWN | fan level 2 after leaving hurricane to standby; busy
// CLEAN    | fan level 3 for CLEAN_SEC, ignores mode_state; busy

module mode_executor #(
    parameter int unsigned TICK_CYCLES   = 100_000_000,
    parameter int unsigned HURRICANE_SEC = 60,
    parameter int unsigned CLEAN_SEC     = 180,
    parameter int unsigned COOLDOWN_SEC  = 60,
    parameter int unsigned USAGE_LIMIT   = 36000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       machine_state,
    input  logic [2:0] mode_state,
    output logic [1:0] fan_level,
    output logic [7:0] remaining_sec,
    output logic       hurricane_exp,
    output logic       clean_done,
    output logic       busy,
    output logic       clean_reminder
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RUN1     = 3'd1;
    localparam logic [2:0] S_RUN2     = 3'd2;
    localparam logic [2:0] S_HURR     = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;
    localparam logic [2:0] S_CLEAN    = 3'd5;

    localparam logic [2:0] M_STANDBY  = 3'b000;
    localparam logic [2:0] M_L1       = 3'b001;
    localparam logic [2:0] M_L2       = 3'b010;
    localparam logic [2:0] M_HURR     = 3'b011;
    localparam logic [2:0] M_CLEAN    = 3'b100;

    localparam int unsigned       DIV_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(TICK_CYCLES - 1);

    // Timers are 8-bit and the usage counter is 16-bit; reject parameters that cannot fit.
    if (TICK_CYCLES == 0) begin : g_bad_tick
        $error("mode_executor: TICK_CYCLES must be at least 1");
    end
    if (HURRICANE_SEC > 255 || CLEAN_SEC > 255 || COOLDOWN_SEC > 255) begin : g_bad_sec
        $error("mode_executor: *_SEC parameters must be <= 255");
    end
    if (USAGE_LIMIT > 65535) begin : g_bad_usage
        $error("mode_executor: USAGE_LIMIT must fit in 16 bits");
    end

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             sec_tick;
    logic             hurricane_used;
    logic             used_nxt;
    logic [7:0]       rem_nxt;
    logic             hexp_nxt;
    logic             cdone_nxt;
    logic [2:0]       mode_eff;
    logic             timer_expire;
    logic             state_change;

    // Where a mode request leads from a state that follows mode_state freely.
    function automatic logic [2:0] mode_target(input logic [2:0] m, input logic used);
        logic [2:0] t;
        case (m)
            M_L1:    t = S_RUN1;
            M_L2:    t = S_RUN2;
            M_HURR:  t = used ? S_RUN2 : S_HURR;
            M_CLEAN: t = S_CLEAN;
            default: t = S_IDLE;
        endcase
        return t;
    endfunction

    function automatic logic [1:0] fan_of(input logic [2:0] s);
        logic [1:0] f;
        case (s)
            S_RUN1:     f = 2'd1;
            S_RUN2:     f = 2'd2;
            S_HURR:     f = 2'd3;
            S_COOLDOWN: f = 2'd2;
            S_CLEAN:    f = 2'd3;
            default:    f = 2'd0;
        endcase
        return f;
    endfunction

    function automatic logic [7:0] load_of(input logic [2:0] s);
        logic [7:0] v;
        case (s)
            S_HURR:     v = 8'(HURRICANE_SEC);
            S_COOLDOWN: v = 8'(COOLDOWN_SEC);
            S_CLEAN:    v = 8'(CLEAN_SEC);
            default:    v = 8'd0;
        endcase
        return v;
    endfunction

    // Reserved codes 101..111 behave as standby.
    assign mode_eff     = (mode_state > M_CLEAN) ? M_STANDBY : mode_state;
    assign sec_tick     = (div_cnt == DIV_MAX);
    // A tick while showing 1 (or 0 for a zero-length timer) is the terminal count.
    assign timer_expire = sec_tick && (remaining_sec <= 8'd1);
    assign state_change = (state_nxt != state);

    // Next-state decode; a mode change always beats a simultaneous expiry.
    always_comb begin
        state_nxt = state;
        hexp_nxt  = 1'b0;
        cdone_nxt = 1'b0;
        if (!machine_state) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_RUN1, S_RUN2: begin
                    state_nxt = mode_target(mode_eff, hurricane_used);
                end
                S_HURR: begin
                    if (mode_eff == M_HURR) begin
                        if (timer_expire) begin
                            state_nxt = S_RUN2;
                            hexp_nxt  = 1'b1;
                        end
                    end else if (mode_eff == M_STANDBY) begin
                        state_nxt = S_COOLDOWN;
                    end else begin
                        state_nxt = mode_target(mode_eff, hurricane_used);
                    end
                end
                S_COOLDOWN: begin
                    if (mode_eff == M_L1) begin
                        state_nxt = S_RUN1;
                    end else if (mode_eff == M_L2) begin
                        state_nxt = S_RUN2;
                    end else if (timer_expire) begin
                        state_nxt = S_IDLE;
                    end
                end
                S_CLEAN: begin
                    if (timer_expire) begin
                        state_nxt = S_IDLE;
                        cdone_nxt = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Countdown and hurricane lockout follow from the chosen next state.
    always_comb begin
        used_nxt = hurricane_used;
        rem_nxt  = remaining_sec;
        if (!machine_state) begin
            used_nxt = 1'b0;
            rem_nxt  = 8'd0;
        end else if (state_change) begin
            rem_nxt = load_of(state_nxt);
            if (state_nxt == S_HURR) begin
                used_nxt = 1'b1;
            end
        end else if (sec_tick && remaining_sec != 8'd0) begin
            rem_nxt = remaining_sec - 8'd1;
        end
    end

    // Registered state, outputs and the second-tick divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            div_cnt        <= '0;
            hurricane_used <= 1'b0;
            fan_level      <= 2'd0;
            remaining_sec  <= 8'd0;
            hurricane_exp  <= 1'b0;
            clean_done     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            hurricane_used <= used_nxt;
            fan_level      <= fan_of(state_nxt);
            remaining_sec  <= rem_nxt;
            hurricane_exp  <= hexp_nxt;
            clean_done     <= cdone_nxt;
            busy           <= (state_nxt == S_COOLDOWN) || (state_nxt == S_CLEAN);
            // Restarting on every state change makes the first second a full one.
            if (state_change || !machine_state || sec_tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

`ifdef CLEAN_REMINDER_EN
    logic [15:0] usage_cnt;
    logic [15:0] usage_nxt;

    // Run-time accumulates while the fan blows outside of self-clean, saturating.
    always_comb begin
        usage_nxt = usage_cnt;
        if (sec_tick && fan_level != 2'd0 && state != S_CLEAN && usage_cnt != 16'hFFFF) begin
            usage_nxt = usage_cnt + 16'd1;
        end
    end

    // Usage counter and reminder survive power-off; only reset or a finished clean clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            usage_cnt      <= 16'd0;
            clean_reminder <= 1'b0;
        end else if (clean_done) begin
            usage_cnt      <= 16'd0;
            clean_reminder <= 1'b0;
        end else begin
            usage_cnt      <= usage_nxt;
            clean_reminder <= (usage_nxt >= 16'(USAGE_LIMIT));
        end
    end
`else
    assign clean_reminder = 1'b0;
`endif

endmodule

// File: tb/tb_mode_executor.sv
// tb_mode_executor: scoreboard bench for mode_executor with small timing parameters.
// Expectations are queued as stimulus is driven and compared once the DUT has responded.

module tb_mode_executor;

    localparam int S_FAN   = 0;
    localparam int S_REM   = 1;
    localparam int S_HEXP  = 2;
    localparam int S_CDONE = 3;
    localparam int S_BUSY  = 4;
    localparam int S_FLAG  = 5;
    localparam int S_MEAS  = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       machine_state;
    logic [2:0] mode_state;
    logic [1:0] fan_level;
    logic [7:0] remaining_sec;
    logic       hurricane_exp;
    logic       clean_done;
    logic       busy;
    logic       clean_reminder;

    int n_chk  = 0;
    int n_fail = 0;
    int meas;
    int cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];

    mode_executor #(
        .TICK_CYCLES  (4),
        .HURRICANE_SEC(3),
        .CLEAN_SEC    (2),
        .COOLDOWN_SEC (2),
        .USAGE_LIMIT  (5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .machine_state (machine_state),
        .mode_state    (mode_state),
        .fan_level     (fan_level),
        .remaining_sec (remaining_sec),
        .hurricane_exp (hurricane_exp),
        .clean_done    (clean_done),
        .busy          (busy),
        .clean_reminder(clean_reminder)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] obs(input int sel);
        case (sel)
            S_FAN:   return 16'(fan_level);
            S_REM:   return 16'(remaining_sec);
            S_HEXP:  return 16'(hurricane_exp);
            S_CDONE: return 16'(clean_done);
            S_BUSY:  return 16'(busy);
            S_FLAG:  return 16'(clean_reminder);
            default: return 16'(meas);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic settle(input int n);
        step(n);
        drain();
    endtask

    task automatic wait_pulse(input int sel, input int budget, output int lat);
        lat = 0;
        while (obs(sel) !== 16'd1 && lat < budget) begin
            step(1);
            lat++;
        end
    endtask

    task automatic push_reset_vals(input string pfx);
        push({pfx, "_fan"},   S_FAN,   16'd0);
        push({pfx, "_rem"},   S_REM,   16'd0);
        push({pfx, "_hexp"},  S_HEXP,  16'd0);
        push({pfx, "_cdone"}, S_CDONE, 16'd0);
        push({pfx, "_busy"},  S_BUSY,  16'd0);
        push({pfx, "_flag"},  S_FLAG,  16'd0);
    endtask

    initial begin
        rst           = 1'b1;
        machine_state = 1'b0;
        mode_state    = 3'b000;
        step(2);
        push_reset_vals("rst");
        drain();

        // power on straight into level 2
        rst = 1'b0; machine_state = 1'b1; mode_state = 3'b010;
        push("l2_fan", S_FAN, 16'd2); push("l2_rem", S_REM, 16'd0); push("l2_busy", S_BUSY, 16'd0);
        settle(1);

        // hurricane runs to its limit
        mode_state = 3'b011;
        push("hurr_fan", S_FAN, 16'd3); push("hurr_rem", S_REM, 16'd3); push("hurr_busy", S_BUSY, 16'd0);
        settle(1);
        push("hurr_rem_dec", S_REM, 16'd2); push("hurr_fan_mid", S_FAN, 16'd3);
        settle(4);
        push("hexp_latency", S_MEAS, 16'd8);
        wait_pulse(S_HEXP, 20, meas);
        push("hexp_fan", S_FAN, 16'd2); push("hexp_rem", S_REM, 16'd0);
        drain();
        push("hexp_width", S_HEXP, 16'd0); push("hexp_after_fan", S_FAN, 16'd2);
        settle(1);

        // hurricane is locked out until power-off
        mode_state = 3'b000;
        push("standby_fan", S_FAN, 16'd0);
        settle(1);
        mode_state = 3'b011;
        push("hurr_used_fan", S_FAN, 16'd2); push("hurr_used_rem", S_REM, 16'd0);
        settle(1);
        mode_state = 3'b101;
        push("reserved_fan", S_FAN, 16'd0);
        settle(1);

        // fresh power-on, hurricane then cooldown
        machine_state = 1'b0;
        push("off_fan", S_FAN, 16'd0); push("off_rem", S_REM, 16'd0); push("off_busy", S_BUSY, 16'd0);
        settle(1);
        machine_state = 1'b1; mode_state = 3'b011;
        push("repower_hurr_fan", S_FAN, 16'd3); push("repower_hurr_rem", S_REM, 16'd3);
        settle(1);
        step(4);
        mode_state = 3'b000;
        push("cool_fan", S_FAN, 16'd2); push("cool_busy", S_BUSY, 16'd1); push("cool_rem", S_REM, 16'd2);
        settle(1);
        mode_state = 3'b100;
        push("cool_ignore_fan", S_FAN, 16'd2); push("cool_ignore_busy", S_BUSY, 16'd1);
        settle(1);
        mode_state = 3'b000;
        push("cool_rem_dec", S_REM, 16'd1);
        settle(3);
        push("cool_end_fan", S_FAN, 16'd0); push("cool_end_busy", S_BUSY, 16'd0);
        push("cool_end_rem", S_REM, 16'd0); push("cool_end_hexp", S_HEXP, 16'd0);
        settle(4);

        // mode change on the expiry tick of cooldown wins
        machine_state = 1'b0;
        push("off2_fan", S_FAN, 16'd0);
        settle(1);
        machine_state = 1'b1; mode_state = 3'b011;
        push("hurr3_fan", S_FAN, 16'd3);
        settle(1);
        mode_state = 3'b000;
        push("cool2_busy", S_BUSY, 16'd1);
        settle(1);
        step(7);
        mode_state = 3'b001;
        push("race_fan", S_FAN, 16'd1); push("race_busy", S_BUSY, 16'd0); push("race_rem", S_REM, 16'd0);
        settle(1);

        // self-clean ignores mode changes, then follows mode_state
        mode_state = 3'b000;
        push("idle_fan", S_FAN, 16'd0);
        settle(1);
        mode_state = 3'b100;
        push("clean_fan", S_FAN, 16'd3); push("clean_busy", S_BUSY, 16'd1); push("clean_rem", S_REM, 16'd2);
        settle(1);
        step(1);
        mode_state = 3'b001;
        push("clean_ignore_fan", S_FAN, 16'd3); push("clean_ignore_busy", S_BUSY, 16'd1);
        settle(1);
        push("cdone_latency", S_MEAS, 16'd6);
        wait_pulse(S_CDONE, 20, meas);
        push("cdone_fan", S_FAN, 16'd0); push("cdone_busy", S_BUSY, 16'd0);
        drain();
        push("post_clean_fan", S_FAN, 16'd1); push("cdone_width", S_CDONE, 16'd0);
        settle(1);

        // power-off during the last second of a clean
        mode_state = 3'b100;
        push("clean2_busy", S_BUSY, 16'd1); push("clean2_rem", S_REM, 16'd2);
        settle(1);
        push("clean2_rem_one", S_REM, 16'd1);
        settle(4);
        step(1);
        machine_state = 1'b0;
        push("pwroff_fan", S_FAN, 16'd0); push("pwroff_busy", S_BUSY, 16'd0);
        push("pwroff_rem", S_REM, 16'd0); push("pwroff_cdone", S_CDONE, 16'd0);
        settle(1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (clean_done === 1'b1) cnt++;
        end
        meas = cnt;
        push("pwroff_no_cdone", S_MEAS, 16'd0);
        drain();

        // reset in the middle of hurricane
        machine_state = 1'b1; mode_state = 3'b011;
        push("hurr4_fan", S_FAN, 16'd3); push("hurr4_rem", S_REM, 16'd3);
        settle(1);
        step(2);
        rst = 1'b1;
        push_reset_vals("midrst");
        settle(1);
        machine_state = 1'b0; mode_state = 3'b000;
        step(1);
        rst = 1'b0;
        step(1);

        // usage reminder after 5 run-seconds
        machine_state = 1'b1; mode_state = 3'b001;
        push("usage_fan", S_FAN, 16'd1);
        settle(1);
        push("usage_flag_early", S_FLAG, 16'd0);
        settle(18);
`ifdef CLEAN_REMINDER_EN
        push("usage_flag_set", S_FLAG, 16'd1);
        settle(2);
        mode_state = 3'b100;
        push("usage_flag_in_clean", S_FLAG, 16'd1); push("usage_clean_busy", S_BUSY, 16'd1);
        settle(1);
        push("usage_cdone_latency", S_MEAS, 16'd8);
        wait_pulse(S_CDONE, 20, meas);
        push("usage_flag_on_cdone", S_FLAG, 16'd1);
        drain();
        push("usage_flag_cleared", S_FLAG, 16'd0);
        settle(1);
`else
        push("usage_flag_tied", S_FLAG, 16'd0);
        settle(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
